// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the fetch-to-decode queue.
// No logic; sizing is evaluated at elaboration.
// No flow control lives here.
package fetch_pkg;

    localparam int FQ_DEPTH_DEFAULT = 4;
    localparam int FQ_XLEN_DEFAULT  = 32;

    // Pointer carries one extra wrap bit above the index bits.
    function automatic int fq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int FQ_PTR_W_DEFAULT = fq_ptr_w(FQ_DEPTH_DEFAULT);

    typedef struct packed {
        logic [FQ_XLEN_DEFAULT-1:0] pc;
        logic [FQ_XLEN_DEFAULT-1:0] instr;
        logic                       misaligned;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry register array, one write port, asynchronous read port.
// Write lands on the clock edge; read is combinational from the array.
// No backpressure; the caller gates writes.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = FQ_DEPTH_DEFAULT,
    parameter type entry_t = fq_entry_t
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  entry_t                     wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output entry_t                     rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue between fetch and decode, flushable in one cycle.
// Latency 1 cycle; 0 cycles when empty if FETCH_QUEUE_BYPASS_EN is defined.
// enq_ready drops when full (no pass-through); decode stalls via deq_ready.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int XLEN  = FQ_XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_instr,
    output logic                     deq_misaligned,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = fq_ptr_w(DEPTH);
    localparam int IW = PW - 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } entry_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          wr_en;
    logic          rd_adv;
    entry_t        wr_ent;
    entry_t        rd_ent;
    entry_t        head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

    assign enq_ready = !full && !reset;
    assign enq_fire  = enq_valid && enq_ready && !flush;

    assign wr_ent.pc         = enq_pc;
    assign wr_ent.instr      = enq_instr;
    assign wr_ent.misaligned = (enq_pc[1:0] != 2'b00);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp;

    // Empty queue forwards the offered entry; it is only stored if decode stalls.
    assign byp       = empty && !flush && !reset;
    assign deq_valid = byp ? enq_valid : (!empty && !flush && !reset);
    assign head      = byp ? wr_ent : rd_ent;
    assign wr_en     = enq_fire && !(byp && deq_ready);
`else
    assign deq_valid = !empty && !flush && !reset;
    assign head      = rd_ent;
    assign wr_en     = enq_fire;
`endif

    // A bypassed consume never touches storage, so the read pointer stays put.
    assign rd_adv = deq_valid && deq_ready && !empty;

    assign deq_pc         = deq_valid ? head.pc         : '0;
    assign deq_instr      = deq_valid ? head.instr      : '0;
    assign deq_misaligned = deq_valid ? head.misaligned : 1'b0;

    assign count = reset ? '0 : (wr_ptr - rd_ptr);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    fq_storage #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[IW-1:0]),
        .wdata (wr_ent),
        .raddr (rd_ptr[IW-1:0]),
        .rdata (rd_ent)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue; bypass expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             enq_valid;
    logic             enq_ready;
    logic [XLEN-1:0]  enq_pc;
    logic [XLEN-1:0]  enq_instr;
    logic             deq_valid;
    logic             deq_ready;
    logic [XLEN-1:0]  deq_pc;
    logic [XLEN-1:0]  deq_instr;
    logic             deq_misaligned;
    logic             flush;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_pc         (enq_pc),
        .enq_instr      (enq_instr),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .deq_misaligned (deq_misaligned),
        .flush          (flush),
        .count          (count)
    );

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] mk_instr(input logic [XLEN-1:0] pc);
        return {pc[15:0], 16'h0013} ^ 32'h5a00_0000;
    endfunction

    // One clock of stimulus; the model decides every handshake independently of the DUT.
    task automatic cycle(input logic ev, input logic [XLEN-1:0] pc, input logic dr, input logic fl);
        exp_t head;
        logic m_vld;
        logic acc;
        int   cnt;
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = mk_instr(pc);
        deq_ready = dr;
        flush     = fl;
        #1;
        cnt   = sb.size();
        m_vld = !fl && (cnt > 0 || (BYP && ev));
        if (cnt > 0) begin
            head = sb[0];
        end else begin
            head.pc    = pc;
            head.instr = mk_instr(pc);
        end
        check("enq_ready", {63'd0, enq_ready}, {63'd0, cnt < DEPTH});
        check("deq_valid", {63'd0, deq_valid}, {63'd0, m_vld});
        if (m_vld) begin
            check("deq_pc", {32'd0, deq_pc}, {32'd0, head.pc});
            check("deq_instr", {32'd0, deq_instr}, {32'd0, head.instr});
            check("deq_misaligned", {63'd0, deq_misaligned}, {63'd0, head.pc[1:0] != 2'b00});
        end else begin
            check("idle_data", {deq_pc, deq_instr[30:0], deq_misaligned}, 64'd0);
        end
        acc = ev && (cnt < DEPTH) && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_vld && dr && cnt > 0) begin
                void'(sb.pop_front());
            end
            if (acc && !(BYP && cnt == 0 && dr)) begin
                head.pc    = pc;
                head.instr = mk_instr(pc);
                sb.push_back(head);
            end
        end
        @(posedge clk);
        #1;
        check("count", {61'd0, count}, 64'(sb.size()));
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        enq_valid = 1'b1;
        enq_pc    = 32'h80;
        enq_instr = mk_instr(32'h80);
        deq_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_enq_ready", {63'd0, enq_ready}, 64'd0);
            check("rst_deq_valid", {63'd0, deq_valid}, 64'd0);
            check("rst_data", {deq_pc, deq_instr[30:0], deq_misaligned}, 64'd0);
            check("rst_count", {61'd0, count}, 64'd0);
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1; enq_valid = 1'b0; enq_pc = '0; enq_instr = '0;
        deq_ready = 1'b0; flush = 1'b0;

        do_reset(2);

        // Fill with decode stalled, then drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
        check("full_count", {61'd0, count}, 64'd4);
        check("full_enq_ready", {63'd0, enq_ready}, 64'd0);

        // Full with both sides active: only the dequeue fires, the offer lands next cycle.
        cycle(1'b1, 32'h10, 1'b1, 1'b0);
        check("full_deq_only", {61'd0, count}, 64'd3);
        cycle(1'b1, 32'h10, 1'b0, 1'b0);
        check("refill_count", {61'd0, count}, 64'd4);

        // Down to two entries, then flush against a live offer of 0x40.
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h40, 1'b1, 1'b1);
        check("flush_count", {61'd0, count}, 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Misaligned flag follows the head PC.
        cycle(1'b1, 32'h102, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-operation loses everything in flight.
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 1'b0, 1'b0);
        do_reset(1);
        #1;
        check("post_rst_count", {61'd0, count}, 64'd0);
        check("post_rst_valid", {63'd0, deq_valid}, 64'd0);

        // Empty queue, offer with decode ready: bypass consumes, otherwise one-cycle latency.
        cycle(1'b1, 32'h20, 1'b1, 1'b0);
        check("byp_count", {61'd0, count}, BYP ? 64'd0 : 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 120; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  32'h200 + 32'(4 * i) + ((i % 7 == 0) ? 32'd2 : 32'd0),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
